// File: rtl/slot_frame_capture.sv
// slot_frame_capture
//   Receive end of the time-division slot stream. Locks onto the 72-step
//   frame (18 slots x 4 stages), samples din once per slot into a shadow
//   buffer and publishes each complete frame into an 18-entry read bank.
//   Sequence breaks while locked drop back to hunting and are counted.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   clkena_i       stream step enable (slot/stage/din valid when 1)
//   slot_i         current slot, legal 0-17
//   stage_i        current stage 0-3
//   din_i          operator output for the current slot
//   rd_addr_i      bank read address, 0-17 (others read as 0)
//   rd_data_o      registered bank read data
//   frame_valid_o  one-clk pulse after a new frame lands in the bank
//   locked_o       1 while tracking a valid frame sequence
//   sync_err_o     one-clk pulse on a sequence mismatch while locked
//   err_count_o    saturating count of sync errors
//
// state  | meaning
// HUNT   | waiting for a step with index 0
// LOCKED | each step must equal the expected index

module slot_frame_capture #(
  parameter int DW        = 10,
  parameter int CAP_STAGE = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clkena_i,
  input  logic [4:0]    slot_i,
  input  logic [1:0]    stage_i,
  input  logic [DW-1:0] din_i,
  input  logic [4:0]    rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          frame_valid_o,
  output logic          locked_o,
  output logic          sync_err_o,
  output logic [7:0]    err_count_o
);

  localparam int          NSLOT    = 18;
  localparam logic [6:0]  LAST_IDX = 7'd71;
  localparam logic [1:0]  CAP_ST   = 2'(CAP_STAGE);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

  state_e        state_q, state_d;
  logic [6:0]    exp_q, exp_d;
  logic [DW-1:0] shadow_q [NSLOT];
  logic [DW-1:0] shadow_d [NSLOT];
  logic [DW-1:0] bank_q   [NSLOT];
  logic [DW-1:0] bank_d   [NSLOT];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          frame_valid_q;
  logic          sync_err_q;
  logic [7:0]    err_count_q, err_count_d;

  logic [6:0]    idx;
  logic          step_start, step_ok, step_bad, capture, publish;

  // Step decode. slot>17 yields idx>=72, which can never equal exp_q,
  // so illegal slots fall out as ordinary mismatches.
  assign idx        = {slot_i, stage_i};
  assign step_start = clkena_i && (state_q == ST_HUNT)   && (idx == 7'd0);
  assign step_ok    = clkena_i && (state_q == ST_LOCKED) && (idx == exp_q);
  assign step_bad   = clkena_i && (state_q == ST_LOCKED) && (idx != exp_q);
  assign capture    = (step_start || step_ok) && (stage_i == CAP_ST);
  assign publish    = step_ok && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (step_start) state_d = ST_LOCKED;
      ST_LOCKED: if (step_bad)   state_d = ST_HUNT;
      default:   state_d = ST_HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    locked_o = (state_q == ST_LOCKED);
  end

  // Datapath next-state
  always_comb begin
    exp_d = exp_q;
    if (step_start) begin
      exp_d = 7'd1;
    end else if (step_ok) begin
      exp_d = (exp_q == LAST_IDX) ? 7'd0 : exp_q + 7'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      shadow_d[i] = shadow_q[i];
      if (step_bad) begin
        shadow_d[i] = '0;
      end else if (capture && (slot_i == 5'(i))) begin
        shadow_d[i] = din_i;
      end
    end
  end

  // Publish takes shadow_d so the slot-17 capture on the last step lands.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      bank_d[i] = publish ? shadow_d[i] : bank_q[i];
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (rd_addr_i == 5'(i)) rd_data_d = bank_q[i];
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (step_bad && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exp_q         <= '0;
      rd_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      exp_q         <= exp_d;
      rd_data_q     <= rd_data_d;
      frame_valid_q <= publish;
      sync_err_q    <= step_bad;
      err_count_q   <= err_count_d;
      for (int i = 0; i < NSLOT; i++) begin
        shadow_q[i] <= shadow_d[i];
        bank_q[i]   <= bank_d[i];
      end
    end
  end

  assign rd_data_o     = rd_data_q;
  assign frame_valid_o = frame_valid_q;
  assign sync_err_o    = sync_err_q;
  assign err_count_o   = err_count_q;

endmodule
